ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register.
- Consumes the latched A/B operands and a start/opcode decode; computes MULT/MULTU/DIV/DIVU in HI/LO.
- Exposes busy so the hazard logic stalls IF/ID and ID/EX while an operation is in flight.
- Supports MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/ex_muldiv_unit_if.sv | 26 ++
 rtl/ex_muldiv_unit.sv | 138 +++++++++++++
 tb/tb_ex_muldiv_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Operand/control bundle between the ID/EX stage and the multiply/divide unit.
// The issuing stage drives the master side; the unit returns HI/LO, busy and done.
interface ex_muldiv_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A_in;
   logic [WIDTH-1:0] B_in;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, A_in, B_in, mthi, mtlo,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, A_in, B_in, mthi, mtlo,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO for the EX stage.
// Works on operand magnitudes for WIDTH cycles, then applies sign fix-up in one extra cycle.
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   ex_muldiv_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [1:0]         r_op;
   logic               r_sign_a;
   logic               r_sign_b;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic               w_sign_diff;

   // op[0] selects the signed variants; unsigned operands are taken raw.
   assign w_neg_a = bus.op[0] & bus.A_in[WIDTH-1];
   assign w_neg_b = bus.op[0] & bus.B_in[WIDTH-1];
   assign w_abs_a = w_neg_a ? -bus.A_in : bus.A_in;
   assign w_abs_b = w_neg_b ? -bus.B_in : bus.B_in;

   // Multiply: {r_rem, r_quo} is the accumulator/multiplier pair, shifted right each step.
   assign w_mul_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

   // Divide: r_quo shifts the dividend out of its top while quotient bits enter at the bottom.
   assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
   assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;

   assign w_sign_diff = r_sign_a ^ r_sign_b;
   assign w_prod      = {r_rem, r_quo};
   assign w_prod_fix  = w_sign_diff ? -w_prod : w_prod;
   // A zero divisor yields an all-ones quotient regardless of operand signs.
   assign w_quo_fix   = (r_b == '0) ? '1 : (w_sign_diff ? -r_quo : r_quo);
   assign w_rem_fix   = r_sign_a ? -r_rem : r_rem;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_next = S_RUN;
         S_RUN:   if (r_count == CNT_W'(WIDTH-1)) w_state_next = S_FIX;
         S_FIX:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op     <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_count  <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_op     <= bus.op;
                  r_sign_a <= w_neg_a;
                  r_sign_b <= w_neg_b;
                  r_count  <= '0;
                  r_rem    <= '0;
                  r_quo    <= w_abs_a;
                  r_b      <= w_abs_b;
               end else begin
                  if (bus.mthi) r_hi <= bus.A_in;
                  if (bus.mtlo) r_lo <= bus.A_in;
               end
            end
            S_RUN: begin
               r_count <= r_count + 1'b1;
               if (r_op[1]) begin
                  r_rem <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], w_div_ge};
               end else begin
                  r_rem <= w_mul_sum[WIDTH:1];
                  r_quo <= {w_mul_sum[0], r_quo[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               r_done <= 1'b1;
               if (r_op[1]) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end else begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
   assign bus.busy = (r_state != S_IDLE);
   assign bus.done = r_done;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic reference model compared every cycle,
// plus hand-computed HI/LO results and latency checks for directed vectors.
module tb_ex_muldiv_unit;
   localparam int LAT = 33;

   logic clk;
   logic reset;

   ex_muldiv_unit_if #(.WIDTH(32)) bus ();

   ex_muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: res = {32'h0, a} * {32'h0, b};
         2'b01: res = sa * sb;
         2'b10: begin
            if (b == 32'h0) res = {a, 32'hFFFFFFFF};
            else            res = {a % b, a / b};
         end
         default: begin
            if (b == 32'h0) res = {a, 32'hFFFFFFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // Model: cycles remaining until the pending result lands.
   int          m_cnt;
   logic [63:0] m_res;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic        m_done;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt  <= 0;
         m_res  <= '0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt == 0) begin
            if (bus.start) begin
               m_res <= ref_result(bus.op, bus.A_in, bus.B_in);
               m_cnt <= LAT;
            end else begin
               if (bus.mthi) m_hi <= bus.A_in;
               if (bus.mtlo) m_lo <= bus.A_in;
            end
         end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_hi   <= m_res[63:32];
               m_lo   <= m_res[31:0];
               m_done <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("model_busy", 32'(bus.busy), 32'(m_cnt != 0));
      check("model_done", 32'(bus.done), 32'(m_done));
      check("model_hi", bus.hi, m_hi);
      check("model_lo", bus.lo, m_lo);
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic with_mtlo, input logic b2b);
      if (!b2b) begin
         @(posedge clk);
         #2;
      end
      bus.start = 1'b1;
      bus.op    = op;
      bus.A_in  = a;
      bus.B_in  = b;
      bus.mtlo  = with_mtlo;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      bus.mtlo  = 1'b0;
      bus.A_in  = ~a;
      bus.B_in  = b ^ 32'h5;
   endtask

   task automatic wait_done(input string name, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input logic chk_len);
      int  n_busy;
      bit  seen;
      n_busy = 0;
      seen   = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1;
            break;
         end
         if (bus.busy) n_busy++;
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL %s_timeout: done never seen, busy cycles %0d, required %0d", name, n_busy, LAT);
      end else begin
         if (chk_len) check({name, "_busy_len"}, 32'(n_busy), 32'(LAT));
         check({name, "_hi"}, bus.hi, exp_hi);
         check({name, "_lo"}, bus.lo, exp_lo);
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.A_in  = '0;
      bus.B_in  = '0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_hi", bus.hi, 32'h0);
      check("rst_lo", bus.lo, 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);

      issue(2'b01, 32'hFFFFFFFD, 32'h5, 1'b0, 1'b0);
      wait_done("mult_neg3x5", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);
      // Launched in the done cycle: back-to-back issue.
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
      wait_done("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b1);
      issue(2'b11, 32'hFFFFFFF9, 32'h2, 1'b0, 1'b0);
      wait_done("div_neg7by2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
      issue(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
      wait_done("divu_100by7", 32'd2, 32'd14, 1'b1);
      issue(2'b10, 32'h12345678, 32'h0, 1'b0, 1'b0);
      wait_done("divu_by0", 32'h12345678, 32'hFFFFFFFF, 1'b1);
      issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      wait_done("div_min_m1", 32'h0, 32'h80000000, 1'b1);
      issue(2'b11, 32'hFFFFFFF9, 32'h0, 1'b0, 1'b0);
      wait_done("div_neg_by0", 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

      @(posedge clk);
      #2;
      bus.mthi = 1'b1;
      bus.mtlo = 1'b1;
      bus.A_in = 32'hAAAA5555;
      @(posedge clk);
      #2;
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      @(negedge clk);
      check("mthi_idle", bus.hi, 32'hAAAA5555);
      check("mtlo_idle", bus.lo, 32'hAAAA5555);

      issue(2'b00, 32'h2, 32'h3, 1'b0, 1'b0);
      bus.mthi = 1'b1;
      bus.A_in = 32'h5A5A5A5A;
      @(negedge clk);
      check("mthi_busy_hi", bus.hi, 32'hAAAA5555);
      @(posedge clk);
      #2 bus.mthi = 1'b0;
      wait_done("multu_2x3", 32'h0, 32'h6, 1'b0);

      issue(2'b00, 32'h11, 32'h2, 1'b1, 1'b0);
      check("start_mtlo_lo", bus.lo, 32'h6);
      check("start_mtlo_busy", 32'(bus.busy), 32'h1);
      wait_done("multu_17x2", 32'h0, 32'h22, 1'b1);

      issue(2'b11, 32'hFFFFFFF9, 32'h2, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'h0);
      check("abort_done", 32'(bus.done), 32'h0);
      check("abort_hi", bus.hi, 32'h0);
      check("abort_lo", bus.lo, 32'h0);
      @(posedge clk);
      #2 reset = 1'b0;
      issue(2'b01, 32'hFFFFFFFD, 32'h5, 1'b0, 1'b0);
      wait_done("mult_after_rst", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
